// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory controller: funct3 encodings, FSM states, access sizing.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Access size in bytes (1, 2, 4 or 8) from funct3[1:0].
  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    return 4'd1 << funct3[1:0];
  endfunction

endpackage

// File: rtl/dmem_align_check.sv
// Combinational access legality check: size decode plus misaligned / out-of-range / illegal-funct3 error.
module dmem_align_check
  import dmem_pkg::*;
#(
  parameter int unsigned XLEN   = 64,
  parameter int unsigned DEPTH  = 2048,
  parameter int unsigned ADDR_W = 64
) (
  input  logic [2:0]        i_funct3,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [3:0]        o_size_c,
  output logic              o_err_c
);

  localparam int unsigned SUM_W = ADDR_W + 1;

  logic w_misaligned;
  logic w_out_of_range;
  logic w_illegal;

  always_comb begin
    o_size_c       = size_bytes(i_funct3);
    w_misaligned   = (i_addr[2:0] & 3'(o_size_c - 4'd1)) != 3'd0;
    // One extra bit keeps addr+size from wrapping near the top of the address space.
    w_out_of_range = ({1'b0, i_addr} + SUM_W'(o_size_c)) > SUM_W'(DEPTH);
    w_illegal      = i_write ? i_funct3[2] : (i_funct3 == 3'b111);
    if (XLEN == 32) begin
      w_illegal = w_illegal | (i_funct3 == F3_D) | (!i_write && (i_funct3 == F3_WU));
    end
    o_err_c = w_misaligned | w_out_of_range | w_illegal;
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Big-endian byte-addressed RV64I data memory with valid/ready handshake and fixed read latency.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned DEPTH   = 2048,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic [7:0] r_mem [DEPTH];

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_req_ready, w_ready_nxt;
  logic              r_resp_valid, w_valid_nxt;
  logic [XLEN-1:0]   r_resp_rdata, w_rdata_nxt;
  logic              r_resp_err, w_err_nxt;

  logic [3:0]        w_size;
  logic              w_err;
  logic              w_accept;
  logic [IDX_W-1:0]  w_idx;
  logic [63:0]       w_raw;
  logic [63:0]       w_ext;
  logic [63:0]       w_wdata;
  logic [63:0]       w_wleft;

  dmem_align_check #(
    .XLEN   (XLEN),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_align (
    .i_funct3 (req_funct3),
    .i_write  (req_write),
    .i_addr   (req_addr),
    .o_size_c (w_size),
    .o_err_c  (w_err)
  );

  assign w_accept = rst_n && (r_state == IDLE) && req_valid;
  assign w_idx    = req_addr[IDX_W-1:0];
  assign w_wdata  = 64'(req_wdata);
  // Left-justify the store bytes so memory byte i is always w_wleft[63-8i -: 8].
  assign w_wleft  = w_wdata << {3'(4'd8 - w_size), 3'b000};

  // Big-endian gather: first byte shifts up to become the most significant.
  always_comb begin
    w_raw = '0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < w_size) begin
        w_raw = {w_raw[55:0], r_mem[w_idx + IDX_W'(i)]};
      end
    end
    case (req_funct3)
      F3_B:    w_ext = {{56{w_raw[7]}},  w_raw[7:0]};
      F3_H:    w_ext = {{48{w_raw[15]}}, w_raw[15:0]};
      F3_W:    w_ext = {{32{w_raw[31]}}, w_raw[31:0]};
      F3_BU,
      F3_HU,
      F3_WU:   w_ext = w_raw;
      default: w_ext = w_raw;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_accept && req_write && !w_err) begin
      for (int i = 0; i < 8; i++) begin
        if (4'(i) < w_size) begin
          r_mem[w_idx + IDX_W'(i)] <= w_wleft[8*(7-i) +: 8];
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_ready_nxt = r_req_ready;
    w_valid_nxt = r_resp_valid;
    w_rdata_nxt = r_resp_rdata;
    w_err_nxt   = r_resp_err;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_ready_nxt = 1'b0;
          w_err_nxt   = w_err;
          w_rdata_nxt = (req_write || w_err) ? '0 : XLEN'(w_ext);
          if (LATENCY <= 1) begin
            w_state_nxt = RESP;
            w_valid_nxt = 1'b1;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt = RESP;
          w_valid_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          w_state_nxt = IDLE;
          w_ready_nxt = 1'b1;
          w_valid_nxt = 1'b0;
          w_rdata_nxt = '0;
          w_err_nxt   = 1'b0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_ready_nxt = 1'b1;
        w_valid_nxt = 1'b0;
        w_rdata_nxt = '0;
        w_err_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_req_ready  <= w_ready_nxt;
      r_resp_valid <= w_valid_nxt;
      r_resp_rdata <= w_rdata_nxt;
      r_resp_err   <= w_err_nxt;
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: three configurations (64/L1, 64/L4, 32/L1) checked against a byte-array model.
module tb_data_memory_ctrl;
  import dmem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid, req_write, resp_ready;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr, req_wdata;
  int          sel;

  logic        rdy0, vld0, err0, rdy1, vld1, err1, rdy2, vld2, err2;
  logic [63:0] rd0, rd1;
  logic [31:0] rd2;

  logic        o_ready, o_valid, o_err;
  logic [63:0] o_rdata;

  int total = 0;
  int bad   = 0;
  logic [7:0] mdl [3][2048];
  int lat_cfg [3] = '{1, 4, 1};

  data_memory_ctrl #(.XLEN(64), .DEPTH(2048), .ADDR_W(64), .LATENCY(1)) u0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid && sel == 0), .req_ready(rdy0),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(vld0), .resp_ready(resp_ready && sel == 0), .resp_rdata(rd0), .resp_err(err0));

  data_memory_ctrl #(.XLEN(64), .DEPTH(2048), .ADDR_W(64), .LATENCY(4)) u1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid && sel == 1), .req_ready(rdy1),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(vld1), .resp_ready(resp_ready && sel == 1), .resp_rdata(rd1), .resp_err(err1));

  data_memory_ctrl #(.XLEN(32), .DEPTH(2048), .ADDR_W(64), .LATENCY(1)) u2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid && sel == 2), .req_ready(rdy2),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata[31:0]),
    .resp_valid(vld2), .resp_ready(resp_ready && sel == 2), .resp_rdata(rd2), .resp_err(err2));

  always_comb begin
    case (sel)
      1:       begin o_ready = rdy1; o_valid = vld1; o_err = err1; o_rdata = rd1; end
      2:       begin o_ready = rdy2; o_valid = vld2; o_err = err2; o_rdata = {32'd0, rd2}; end
      default: begin o_ready = rdy0; o_valid = vld0; o_err = err0; o_rdata = rd0; end
    endcase
  end

  // Reference: legality from the access rules, big-endian bytes in a flat array, arithmetic extension.
  task automatic model(input int s, input logic w, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd, output logic [63:0] rd, output logic er);
    int sz, xl;
    bit ill;
    logic [63:0] v;
    xl = (s == 2) ? 32 : 64;
    sz = 1 << f3[1:0];
    ill = w ? f3[2] : (f3 == 3'b111);
    if (xl == 32 && (f3 == 3'b011 || (!w && f3 == 3'b110))) ill = 1;
    er = ill || (a > 64'(2048 - sz)) || ((a % 64'(sz)) != 0);
    rd = '0;
    if (er) return;
    if (w) begin
      for (int i = 0; i < sz; i++) mdl[s][int'(a) + i] = 8'(wd >> (8 * (sz - 1 - i)));
    end else begin
      v = '0;
      for (int i = 0; i < sz; i++) v = (v << 8) | 64'(mdl[s][int'(a) + i]);
      if (!f3[2] && sz < 8 && v[8*sz-1]) v = v | (~64'd0 << (8 * sz));
      if (xl == 32) v = v & 64'hFFFF_FFFF;
      rd = v;
    end
  endtask

  task automatic issue(input logic w, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
    int n = 0;
    while (!o_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!o_ready) begin
      total++; bad++;
      $display("FAIL issue_timeout req_ready=%b exp=1", o_ready);
    end
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 1;
    while (!o_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    if (!o_valid) begin
      total++; bad++;
      $display("FAIL resp_timeout resp_valid=%b exp=1", o_valid);
    end
  endtask

  task automatic consume();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic xact(input logic w, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd,
                      output logic [63:0] rd, output logic er, output int lat);
    issue(w, f3, a, wd);
    wait_resp(lat);
    rd = o_rdata; er = o_err;
    consume();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      total += 4;
      if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready[%0d] got=%b exp=1", s, o_ready); end
      if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid[%0d] got=%b exp=0", s, o_valid); end
      if (o_rdata !== 64'd0) begin bad++; $display("FAIL reset_rdata[%0d] got=%h exp=0", s, o_rdata); end
      if (o_err !== 1'b0) begin bad++; $display("FAIL reset_err[%0d] got=%b exp=0", s, o_err); end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_table(input int s, input string name, input logic tw [], input logic [2:0] tf [],
                            input logic [63:0] ta [], input logic [63:0] td []);
    logic [63:0] erd, rd;
    logic eer, er;
    int lat;
    sel = s; #1;
    for (int k = 0; k < tw.size(); k++) begin
      model(s, tw[k], tf[k], ta[k], td[k], erd, eer);
      xact(tw[k], tf[k], ta[k], td[k], rd, er, lat);
      total++;
      if (rd !== erd || er !== eer || lat != lat_cfg[s]) begin
        bad++;
        $display("FAIL %s[%0d] rdata=%h err=%b lat=%0d exp_rdata=%h exp_err=%b exp_lat=%0d",
                 name, k, rd, er, lat, erd, eer, lat_cfg[s]);
      end
    end
  endtask

  task automatic test_basic();
    logic tw [] = '{1, 0, 0, 1, 0, 0, 1, 0};
    logic [2:0] tf [] = '{F3_D, F3_D, F3_BU, F3_B, F3_B, F3_BU, F3_H, F3_HU};
    logic [63:0] ta [] = '{0, 0, 0, 16, 16, 16, 18, 18};
    logic [63:0] td [] = '{64'h0102030405060708, 0, 0, 64'h80, 0, 0, 64'h8001, 0};
    test_table(0, "basic", tw, tf, ta, td);
  endtask

  task automatic test_errors();
    logic tw [] = '{1, 0, 1, 0, 0, 1, 0};
    logic [2:0] tf [] = '{F3_D, F3_W, F3_D, F3_D, F3_D, 3'b100, 3'b111};
    logic [63:0] ta [] = '{2040, 6, 2044, 2040, 64'hFFFF_FFFF_FFFF_FFF8, 8, 8};
    logic [63:0] td [] = '{64'h1122334455667788, 0, 64'hAAAAAAAAAAAAAAAA, 0, 0, 64'h55, 0};
    test_table(0, "errors", tw, tf, ta, td);
  endtask

  task automatic test_latency_hold();
    logic [63:0] erd, rd, drd;
    logic eer, er;
    int lat;
    sel = 1; #1;
    model(1, 1, F3_D, 0, 64'hCAFEF00D_12345678, drd, eer);
    xact(1, F3_D, 0, 64'hCAFEF00D_12345678, rd, er, lat);
    model(1, 1, F3_B, 100, 64'h11, drd, eer);
    xact(1, F3_B, 100, 64'h11, rd, er, lat);
    model(1, 0, F3_D, 0, 0, erd, eer);
    issue(0, F3_D, 0, 0);
    wait_resp(lat);
    total++;
    if (lat != 4) begin bad++; $display("FAIL hold_latency got=%0d exp=4", lat); end
    for (int c = 0; c < 3; c++) begin
      req_valid = 1'b1; req_write = 1'b1; req_funct3 = F3_B; req_addr = 100; req_wdata = 64'h22;
      @(posedge clk); #1;
      total++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_rdata !== erd || o_err !== eer) begin
        bad++;
        $display("FAIL hold[%0d] valid=%b ready=%b rdata=%h err=%b exp 1 0 %h %b",
                 c, o_valid, o_ready, o_rdata, o_err, erd, eer);
      end
    end
    req_valid = 1'b0;
    consume();
    total++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      bad++; $display("FAIL hold_release ready=%b valid=%b exp 1 0", o_ready, o_valid);
    end
    model(1, 0, F3_BU, 100, 0, erd, eer);
    xact(0, F3_BU, 100, 0, rd, er, lat);
    total++;
    if (rd !== erd || er !== eer) begin
      bad++; $display("FAIL ignored_store rdata=%h err=%b exp=%h %b", rd, er, erd, eer);
    end
  endtask

  task automatic test_reset_wait();
    logic [63:0] erd, rd;
    logic eer, er;
    int lat;
    sel = 1; #1;
    model(1, 1, F3_W, 32, 64'hDEADBEEF, erd, eer);
    issue(1, F3_W, 32, 64'hDEADBEEF);
    rst_n = 1'b0;
    @(posedge clk); #1;
    total++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      bad++; $display("FAIL reset_wait valid=%b ready=%b exp 0 1", o_valid, o_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    model(1, 0, F3_WU, 32, 0, erd, eer);
    xact(0, F3_WU, 32, 0, rd, er, lat);
    total++;
    if (rd !== erd || er !== eer || rd !== 64'hDEADBEEF) begin
      bad++; $display("FAIL reset_wait_load rdata=%h err=%b exp=%h %b", rd, er, erd, eer);
    end
  endtask

  task automatic test_xlen32();
    logic tw [] = '{1, 0, 0, 0, 1, 0, 0, 1};
    logic [2:0] tf [] = '{F3_W, F3_W, F3_WU, F3_D, F3_D, 3'b111, F3_H, 3'b101};
    logic [63:0] ta [] = '{0, 0, 0, 0, 8, 0, 0, 4};
    logic [63:0] td [] = '{64'h80000001, 0, 0, 0, 64'h1, 0, 0, 64'h1};
    test_table(2, "xlen32", tw, tf, ta, td);
  endtask

  task automatic test_random();
    logic [63:0] erd, rd, a, wd;
    logic eer, er, w;
    logic [2:0] f3;
    int lat, sz;
    for (int s = 0; s < 3; s++) begin
      sel = s; #1;
      for (int b = 0; b < 264; b += 4) begin
        a = (b < 256) ? 64'(b) : 64'(2040 + b - 256);
        wd = {$urandom, $urandom};
        model(s, 1, F3_W, a, wd, erd, eer);
        xact(1, F3_W, a, wd, rd, er, lat);
      end
      for (int k = 0; k < 80; k++) begin
        f3 = 3'($urandom_range(0, 7));
        w  = 1'($urandom_range(0, 1));
        sz = 1 << f3[1:0];
        a  = ($urandom_range(0, 9) < 8) ? 64'($urandom_range(0, 255)) : 64'($urandom_range(2040, 2060));
        if ($urandom_range(0, 3) != 0) a = a & ~64'(sz - 1);
        wd = {$urandom, $urandom};
        model(s, w, f3, a, wd, erd, eer);
        xact(w, f3, a, wd, rd, er, lat);
        total++;
        if (rd !== erd || er !== eer || lat != lat_cfg[s]) begin
          bad++;
          $display("FAIL random[%0d.%0d] w=%b f3=%0d a=%0d rdata=%h err=%b lat=%0d exp=%h %b %0d",
                   s, k, w, f3, a, rd, er, lat, erd, eer, lat_cfg[s]);
        end
      end
    end
  endtask

  initial begin
    sel = 0; rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; resp_ready = 1'b0;
    req_funct3 = '0; req_addr = '0; req_wdata = '0;
    test_reset();
    test_basic();
    test_errors();
    test_latency_hold();
    test_reset_wait();
    test_xlen32();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
